// File: rtl/yarp_execute_mc.sv
// YARP execute stage: registered single-cycle base ALU plus iterative RV32M multiply/divide.
// The M-extension datapath is only built when YARP_EXEC_MDU_EN is defined.

package yarp_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;
endpackage

module yarp_execute_mc
  import yarp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [3:0]      op_sel_i,
  input  logic            mdu_en_i,
  input  logic [2:0]      mdu_op_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_res_o,
  output logic            illegal_o
);

  localparam int unsigned SHW = $clog2(XLEN);

`ifdef YARP_EXEC_MDU_EN
  localparam int unsigned CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, HOLD = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd3} state_e;
`endif

  state_e          state_q, state_d;
  logic            valid_q, illegal_q;
  logic [XLEN-1:0] res_q;
  logic            accept_c;

  // Base ALU
  logic [XLEN-1:0] alu_res_c;
  logic            alu_ill_c;
  logic [SHW-1:0]  shamt_c;

  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    shamt_c   = opr_b_i[SHW-1:0];
    case (op_sel_i)
      OP_ADD:  alu_res_c = opr_a_i + opr_b_i;
      OP_SUB:  alu_res_c = opr_a_i - opr_b_i;
      OP_SLL:  alu_res_c = opr_a_i << shamt_c;
      OP_SRL:  alu_res_c = opr_a_i >> shamt_c;
      OP_SRA:  alu_res_c = XLEN'($signed(opr_a_i) >>> shamt_c);
      OP_OR:   alu_res_c = opr_a_i | opr_b_i;
      OP_AND:  alu_res_c = opr_a_i & opr_b_i;
      OP_XOR:  alu_res_c = opr_a_i ^ opr_b_i;
      OP_SLTU: alu_res_c = XLEN'(opr_a_i < opr_b_i);
      OP_SLT:  alu_res_c = XLEN'($signed(opr_a_i) < $signed(opr_b_i));
      default: alu_ill_c = 1'b1;
    endcase
  end

`ifdef YARP_EXEC_MDU_EN
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step_c, prod_c;
  logic [XLEN-1:0]   opb_q;
  logic [2:0]        op_q;
  logic              neg_res_q, neg_rem_q;

  logic              sgn_a_c, sgn_b_c, div_zero_c, div_ovf_c, mdu_special_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c, special_res_c;
  logic [XLEN:0]     mul_sum_c, div_shift_c, div_next_c;
  logic              div_ge_c;
  logic [XLEN-1:0]   quo_c, rem_c, mdu_res_c;

  // Operand signs/magnitudes and the single-cycle divide corner cases
  always_comb begin
    sgn_a_c    = (mdu_op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) && opr_a_i[XLEN-1];
    sgn_b_c    = (mdu_op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM}) && opr_b_i[XLEN-1];
    mag_a_c    = sgn_a_c ? -opr_a_i : opr_a_i;
    mag_b_c    = sgn_b_c ? -opr_b_i : opr_b_i;
    div_zero_c = mdu_op_i[2] && (opr_b_i == '0);
    div_ovf_c  = (mdu_op_i == MDU_DIV || mdu_op_i == MDU_REM) &&
                 (opr_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (opr_b_i == '1);
    mdu_special_c = div_zero_c || div_ovf_c;
    if (div_zero_c) special_res_c = mdu_op_i[1] ? opr_a_i : '1;
    else            special_res_c = mdu_op_i[1] ? '0 : opr_a_i;
  end

  // One shift-add or restoring-subtract step, plus the final sign fix-up
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift_c = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge_c    = div_shift_c >= {1'b0, opb_q};
    div_next_c  = div_ge_c ? div_shift_c - {1'b0, opb_q} : div_shift_c;
    if (state_q == DIV) acc_step_c = {div_next_c[XLEN-1:0], acc_q[XLEN-2:0], div_ge_c};
    else                acc_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    prod_c = neg_res_q ? -acc_q : acc_q;
    quo_c  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_c  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])              mdu_res_c = op_q[1] ? rem_c : quo_c;
    else if (op_q == MDU_MUL) mdu_res_c = prod_c[XLEN-1:0];
    else                      mdu_res_c = prod_c[2*XLEN-1:XLEN];
  end
`else
  logic unused_mdu_op;
  assign unused_mdu_op = ^mdu_op_i;
`endif

  assign accept_c = valid_i && ready_o && !flush_i;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = ready_i ? IDLE : HOLD;
`ifdef YARP_EXEC_MDU_EN
          if (mdu_en_i && !mdu_special_c) state_d = mdu_op_i[2] ? DIV : MUL;
`endif
        end
      end
`ifdef YARP_EXEC_MDU_EN
      MUL, DIV: if (cnt_q == '0) state_d = ready_i ? IDLE : HOLD;
`endif
      HOLD:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    ready_o   = (state_q == IDLE) && !(valid_q && !ready_i);
    valid_o   = valid_q;
    alu_res_o = res_q;
    illegal_o = illegal_q;
  end

  // Result register and iterative datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      res_q     <= '0;
      illegal_q <= 1'b0;
`ifdef YARP_EXEC_MDU_EN
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else if (flush_i) begin
      valid_q <= 1'b0;
`ifdef YARP_EXEC_MDU_EN
      cnt_q   <= '0;
`endif
    end else begin
      if (valid_q && ready_i) valid_q <= 1'b0;
      if (accept_c) begin
        valid_q   <= 1'b1;
        res_q     <= alu_res_c;
        illegal_q <= alu_ill_c;
        if (mdu_en_i) begin
`ifdef YARP_EXEC_MDU_EN
          illegal_q <= 1'b0;
          if (mdu_special_c) begin
            res_q <= special_res_c;
          end else begin
            valid_q   <= 1'b0;
            acc_q     <= {{XLEN{1'b0}}, mag_a_c};
            opb_q     <= mag_b_c;
            op_q      <= mdu_op_i;
            neg_res_q <= sgn_a_c ^ sgn_b_c;
            neg_rem_q <= sgn_a_c;
            cnt_q     <= CW'(XLEN);
          end
`else
          res_q     <= '0;
          illegal_q <= 1'b1;
`endif
        end
      end
`ifdef YARP_EXEC_MDU_EN
      if (state_q == MUL || state_q == DIV) begin
        if (cnt_q == '0) begin
          res_q     <= mdu_res_c;
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
        end else begin
          acc_q <= acc_step_c;
          cnt_q <= cnt_q - CW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_yarp_execute_mc.sv
// Directed self-checking bench for yarp_execute_mc; expected results queue on accept and
// are compared when the DUT hands a result downstream.

module tb_yarp_execute_mc;
  import yarp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, valid_i, ready_o, mdu_en_i, flush_i, valid_o, ready_i, illegal_o;
  logic [31:0] opr_a_i, opr_b_i, alu_res_o;
  logic [3:0]  op_sel_i;
  logic [2:0]  mdu_op_i;

  yarp_execute_mc #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .op_sel_i(op_sel_i), .mdu_en_i(mdu_en_i),
    .mdu_op_i(mdu_op_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .alu_res_o(alu_res_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    string       tag;
  } exp_t;

  typedef struct {
    logic        mdu;
    logic [3:0]  op;
    logic [2:0]  mop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
    string       tag;
  } tv_t;

  exp_t        exp_q[$];
  exp_t        pend;
  int          n_vec = 0;
  int          n_miss = 0;
  logic        s_valid, s_ready, s_acc, s_ill;
  logic [31:0] s_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge, settle the scoreboard, then advance past the next rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_valid = valid_o; s_ready = ready_o; s_res = alu_res_o; s_ill = illegal_o; s_acc = 1'b0;
    if (!reset_n || flush_i) begin
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_res"}, alu_res_o, e.res);
          check({e.tag, "_ill"}, 32'(illegal_o), 32'(e.ill));
        end
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(pend);
        s_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input tv_t t, output int waited);
    mdu_en_i = t.mdu; op_sel_i = t.op; mdu_op_i = t.mop;
    opr_a_i = t.a; opr_b_i = t.b; valid_i = 1'b1;
    pend.res = t.res; pend.ill = t.ill; pend.tag = t.tag;
    waited = 0;
    do begin tick(); waited++; end while (!s_acc && waited < 200);
    if (!s_acc) check({t.tag, "_accept_timeout"}, 32'(s_acc), 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic ro_seen);
    lat = 0; ro_seen = 1'b0;
    do begin
      tick(); lat++;
      if (!s_valid && s_ready) ro_seen = 1'b1;
    end while (!s_valid && lat < 100);
  endtask

  tv_t base_tv [10] = '{
    '{1'b0, OP_ADD,  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1, "add_ovf"},
    '{1'b0, OP_SLT,  3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, "slt"},
    '{1'b0, OP_SLTU, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, "sltu"},
    '{1'b0, OP_SRA,  3'd0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1, "sra"},
    '{1'b0, OP_SUB,  3'd0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1, "sub"},
    '{1'b0, OP_SLL,  3'd0, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1, "sll_lowbits"},
    '{1'b0, OP_SRL,  3'd0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1, "srl"},
    '{1'b0, OP_OR,   3'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1, "or"},
    '{1'b0, OP_AND,  3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1, "and"},
    '{1'b0, 4'b1111, 3'd0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1, "illegal_op"}
  };

`ifdef YARP_EXEC_MDU_EN
  tv_t mdu_tv [11] = '{
    '{1'b1, OP_ADD, MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, "mulh"},
    '{1'b1, OP_ADD, MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu"},
    '{1'b1, OP_ADD, MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, "mul_neg"},
    '{1'b1, OP_ADD, MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, "mulhu"},
    '{1'b1, OP_ADD, MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33, "div_neg"},
    '{1'b1, OP_ADD, MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33, "rem_neg"},
    '{1'b1, OP_ADD, MDU_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33, "divu"},
    '{1'b1, OP_ADD, MDU_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 33, "remu"},
    '{1'b1, OP_ADD, MDU_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1,  "divu_by0"},
    '{1'b1, OP_ADD, MDU_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1,  "rem_by0"},
    '{1'b1, OP_ADD, MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1,  "div_ovf"}
  };
`endif

  tv_t add5 = '{1'b0, OP_ADD, 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add_2_3"};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, lat, tot;
    logic ro, bad_stable, bad_ready;
    tv_t  t;

    reset_n = 1'b0; valid_i = 1'b0; mdu_en_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    op_sel_i = OP_ADD; mdu_op_i = 3'd0; opr_a_i = '0; opr_b_i = '0;
    pend = '{32'd0, 1'b0, "none"};
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res", alu_res_o, 32'd0);
    check("rst_ill", 32'(illegal_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);

    // Back-to-back base ops: each is accepted on its first cycle
    tot = 0;
    foreach (base_tv[i]) begin
      issue(base_tv[i], w);
      tot += w;
    end
    check("base_throughput_cycles", 32'(tot), 32'd10);
    wait_valid(lat, ro);
    check("base_last_latency", 32'(lat), 32'd1);

    // Back-pressure: result stays put while downstream stalls
    t = '{1'b0, OP_XOR, 3'd0, 32'hF0F0_1234, 32'h0F0F_0000, 32'hFFFF_1234, 1'b0, 1, "bp_xor"};
    issue(t, w);
    ready_i = 1'b0;
    bad_stable = 1'b0; bad_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!s_valid || s_res !== 32'hFFFF_1234 || s_ill !== 1'b0) bad_stable = 1'b1;
      if (s_ready !== 1'b0) bad_ready = 1'b1;
    end
    check("bp_output_stable", 32'(bad_stable), 32'd0);
    check("bp_ready_low", 32'(bad_ready), 32'd0);
    ready_i = 1'b1;
    issue(add5, w);
    check("bp_release_same_edge_accept", 32'(w), 32'd1);
    wait_valid(lat, ro);
    check("bp_next_latency", 32'(lat), 32'd1);

    // Flush drops a held result
    t = '{1'b0, OP_ADD, 3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1, "fl_held"};
    issue(t, w);
    ready_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_held_valid", 32'(valid_o), 32'd0);
    check("flush_held_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b1;

`ifdef YARP_EXEC_MDU_EN
    foreach (mdu_tv[i]) begin
      issue(mdu_tv[i], w);
      wait_valid(lat, ro);
      check({mdu_tv[i].tag, "_latency"}, 32'(lat), 32'(mdu_tv[i].lat));
      check({mdu_tv[i].tag, "_ready_busy"}, 32'(ro), 32'd0);
    end

    // Flush in cycle 10 of a divide; the same-cycle request must be ignored
    t = '{1'b1, OP_ADD, MDU_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 33, "fl_div"};
    issue(t, w);
    repeat (9) tick();
    flush_i = 1'b1; valid_i = 1'b1; mdu_en_i = 1'b0; op_sel_i = OP_ADD;
    opr_a_i = 32'd9; opr_b_i = 32'd9;
    pend = '{32'd18, 1'b0, "fl_same_cycle"};
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_div_valid", 32'(valid_o), 32'd0);
    check("flush_div_ready", 32'(ready_o), 32'd1);
    issue(add5, w);
    wait_valid(lat, ro);
    check("flush_div_add_latency", 32'(lat), 32'd1);

    t = '{1'b1, OP_ADD, MDU_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33, "rst_mul"};
    issue(t, w);
    repeat (5) tick();
`else
    t = '{1'b1, OP_ADD, MDU_MUL, 32'd3, 32'd4, 32'd0, 1'b1, 1, "nomdu_mul"};
    issue(t, w);
    wait_valid(lat, ro);
    check("nomdu_mul_latency", 32'(lat), 32'd1);

    t = '{1'b0, OP_ADD, 3'd0, 32'd7, 32'd7, 32'd14, 1'b0, 1, "rst_held"};
    issue(t, w);
    ready_i = 1'b0;
    repeat (3) tick();
    ready_i = 1'b1;
`endif

    // Synchronous reset mid-operation discards everything
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_res", alu_res_o, 32'd0);
    issue(add5, w);
    wait_valid(lat, ro);
    check("midrst_add_latency", 32'(lat), 32'd1);

    repeat (2) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/yarp_execute_mc.md
# yarp_execute_mc

Multi-cycle execute unit for the YARP core. It is the parametrised successor of the single-cycle RV32I ALU stage. It performs every base ALU operation in one registered cycle and the RV32M multiply/divide operations iteratively. Input and output use valid/ready handshakes so the stage stalls cleanly on downstream (cache) back-pressure. It sits between decode/operand-fetch and memory/writeback.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64; shift amount uses low $clog2(XLEN) bits of opr_b_i.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- valid_i  in  1  operation presented.
- ready_o  out  1  unit can accept an operation this cycle.
- opr_a_i  in  XLEN  source operand A.
- opr_b_i  in  XLEN  source operand B.
- op_sel_i  in  4  base ALU op, yarp_pkg encoding (OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_XOR, OP_SLT, OP_SLTU).
- mdu_en_i  in  1  1 = M-extension op; op_sel_i is then ignored.
- mdu_op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- flush_i  in  1  abort any in-flight operation and drop held result.
- valid_o  out  1  alu_res_o holds a result.
- ready_i  in  1  downstream accepts result (driven as !cache_busy).
- alu_res_o  out  XLEN  result.
- illegal_o  out  1  qualifies valid_o; result came from an unsupported op.

## Operation
- FSM states: IDLE, MUL, DIV, HOLD.
- ready_o = (state==IDLE) && !(valid_o && !ready_i).
- Accept = valid_i && ready_o.
- Base ALU accept: result registered next edge; state becomes HOLD, or stays IDLE if already consumed.
- SLT is a true signed compare, SLTU unsigned. Both return {XLEN-1 zeros, bit}.
- SRA is arithmetic. Undefined op_sel_i returns 0 with illegal_o=1.
- MUL*: shift-add over magnitudes, 2*XLEN-bit product, XLEN iterations, sign fixed at end.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - MULHSU treats A as signed and B as unsigned.
- DIV*: restoring divide on magnitudes, XLEN iterations; quotient sign = sign(A)^sign(B), remainder sign = sign(A).
- Divide by zero: quotient all ones, remainder = A; takes 1 cycle, no iteration.
- Signed overflow (A = most-negative, B = -1): quotient = A, remainder = 0; takes 1 cycle.
- Iteration counter is $clog2(XLEN)+1 bits, loaded with XLEN, decremented each cycle; finishing at 0 registers the result and sets valid_o.
- Output is held stable (value, illegal_o) while valid_o && !ready_i.
- flush_i has priority over everything except reset. Next edge: state=IDLE, valid_o=0; same-cycle valid_i is not accepted.
- Reset mid-operation discards all state.

## Timing
- Reset values: valid_o=0, alu_res_o=0, illegal_o=0, state=IDLE, counter=0. ready_o=1 the cycle after reset.
- Base ALU latency: 1 cycle. Back-to-back throughput is 1/cycle when ready_i=1.
- MUL*/DIV* latency: XLEN+1 cycles (33 at XLEN=32), measured from the accept edge to valid_o. ready_o=0 throughout.
- Divide special cases: latency 1 cycle.
- Result is consumed on the edge where valid_o && ready_i. A new op may be accepted on that same edge.
- Stall during MUL/DIV does not pause iteration; the result waits in HOLD.

## Configuration
- YARP_EXEC_MDU_EN defined: M-extension ops supported as above.
- YARP_EXEC_MDU_EN undefined: multiplier, divider, counter and the MUL/DIV states are not built.
  - Any accept with mdu_en_i=1 completes in 1 cycle with alu_res_o=0 and illegal_o=1.

## Test plan
- Base ops at XLEN=32, ready_i=1, back-to-back:
  - ADD 0x7FFFFFFF+1 -> 0x80000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - One result per cycle.
- Multiply:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 7×-3 -> 0xFFFFFFEB.
  - valid_o exactly 33 cycles after accept; ready_o=0 meanwhile.
- Divide and corners:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000 in 1 cycle.
- Back-pressure: hold ready_i=0 for 10 cycles after valid_o -> alu_res_o stable, ready_o=0. Release -> consumed, next op accepted on the same edge.
- flush_i at cycle 10 of a DIV, and separately reset_n=0 mid-MUL -> valid_o=0 and IDLE next edge; the subsequent ADD 2+3 returns 5 in 1 cycle.
- Build without YARP_EXEC_MDU_EN: MUL 3×4 -> valid_o after 1 cycle, alu_res_o=0, illegal_o=1.
